// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - shared offsets, FSM states and status bit positions for wb_fir_sequencer
package fir_seq_pkg;

    localparam logic [11:0] OFF_AP_CTRL    = 12'h000;
    localparam logic [11:0] OFF_LEN        = 12'h010;
    localparam logic [11:0] OFF_X_IN       = 12'h080;
    localparam logic [11:0] OFF_Y_OUT      = 12'h084;
    localparam logic [11:0] OFF_STATUS     = 12'h088;
    localparam logic [11:0] OFF_LITE_LIMIT = 12'h080;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LWR   = 3'd1,
        ST_LRD_A = 3'd2,
        ST_LRD_D = 3'd3,
        ST_XPUSH = 3'd4,
        ST_ACK   = 3'd5
    } seq_state_e;

    localparam int STAT_Y_FULL   = 0;
    localparam int STAT_SS_READY = 1;
    localparam int STAT_ERR      = 2;
    localparam int STAT_Y_LAST   = 3;
    localparam int STAT_XCNT_LSB = 16;

endpackage

// File: rtl/fir_y_buf.sv
// rtl/fir_y_buf.sv - one-entry capture buffer for the FIR Y output stream
module fir_y_buf #(
    parameter int pDATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast,
    input  logic                   pop,
    output logic                   sm_tready,
    output logic                   y_full,
    output logic [pDATA_WIDTH-1:0] y_data,
    output logic                   y_last
);

    logic                   full_q, full_d;
    logic                   ready_q, ready_d;
    logic                   last_q, last_d;
    logic [pDATA_WIDTH-1:0] data_q, data_d;

    // Capture on handshake, release on pop; ready is simply the registered inverse of full
    always_comb begin
        full_d = full_q;
        last_d = last_q;
        data_d = data_q;
        if (sm_tvalid && ready_q) begin
            full_d = 1'b1;
            data_d = sm_tdata;
            last_d = sm_tlast;
        end else if (pop) begin
            full_d = 1'b0;
        end
        ready_d = ~full_d;
    end

    // Buffer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            ready_q <= 1'b1;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= ready_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign sm_tready = ready_q;
    assign y_full    = full_q;
    assign y_data    = data_q;
    assign y_last    = last_q;

endmodule

// File: rtl/wb_fir_sequencer.sv
// rtl/wb_fir_sequencer.sv - Wishbone slave sequencing FIR AXI-Lite config, X pushes and Y pops
module wb_fir_sequencer
    import fir_seq_pkg::*;
#(
    parameter int          pADDR_WIDTH = 12,
    parameter int          pDATA_WIDTH = 32,
    parameter logic [11:0] ADDR_BASE   = 12'h300,
    parameter int          TIMEOUT     = 255
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic                   awvalid,
    output logic [pADDR_WIDTH-1:0] awaddr,
    output logic                   wvalid,
    output logic [pDATA_WIDTH-1:0] wdata,
    input  logic                   awready,
    input  logic                   wready,
    output logic                   arvalid,
    output logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rready,
    input  logic                   arready,
    input  logic                   rvalid,
    input  logic [pDATA_WIDTH-1:0] rdata,
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready,
    output logic                   sm_tready,
    input  logic                   sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast
);

    localparam int                     WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0]      WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(OFF_LEN);
    localparam logic [pADDR_WIDTH-1:0] ADDR_AP   = pADDR_WIDTH'(OFF_AP_CTRL);
    localparam logic [pDATA_WIDTH-1:0] ONE       = pDATA_WIDTH'(1);

    seq_state_e             state_q, state_d;
    logic                   ack_q, ack_d;
    logic [31:0]            dat_o_q, dat_o_d;
    logic                   awvalid_q, awvalid_d;
    logic                   wvalid_q, wvalid_d;
    logic                   arvalid_q, arvalid_d;
    logic                   rready_q, rready_d;
    logic                   ss_tvalid_q, ss_tvalid_d;
    logic [pADDR_WIDTH-1:0] addr_q, addr_d;
    logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [pDATA_WIDTH-1:0] len_q, len_d;
    logic [pDATA_WIDTH-1:0] x_cnt_q, x_cnt_d;
    logic                   err_q, err_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;

    logic                   hit;
    logic [11:0]            off;
    logic                   x_last;
    logic                   timed_out;
    logic                   do_timeout;
    logic                   err_clr;
    logic [31:0]            status;
    logic                   y_pop;
    logic                   y_full;
    logic                   y_last;
    logic [pDATA_WIDTH-1:0] y_data;
    logic                   unused_sig;

    assign unused_sig = ^{wbs_sel_i, wbs_adr_i[19:12]};

    fir_y_buf #(
        .pDATA_WIDTH(pDATA_WIDTH)
    ) u_y_buf (
        .clk      (axis_clk),
        .rst_n    (axis_rst_n),
        .sm_tvalid(sm_tvalid),
        .sm_tdata (sm_tdata),
        .sm_tlast (sm_tlast),
        .pop      (y_pop),
        .sm_tready(sm_tready),
        .y_full   (y_full),
        .y_data   (y_data),
        .y_last   (y_last)
    );

    assign hit       = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:20] == ADDR_BASE);
    assign off       = wbs_adr_i[11:0];
    assign x_last    = (len_q != '0) && (x_cnt_q == len_q - ONE);
    assign timed_out = (wait_q == WAIT_LAST);

    // Status word assembled from live flags
    always_comb begin
        status                    = '0;
        status[STAT_Y_FULL]       = y_full;
        status[STAT_SS_READY]     = ss_tready;
        status[STAT_ERR]          = err_q;
        status[STAT_Y_LAST]       = y_last;
        status[31:STAT_XCNT_LSB]  = x_cnt_q[15:0];
    end

    // Next-state and output decode; every access funnels through ACK
    always_comb begin
        state_d     = state_q;
        ack_d       = 1'b0;
        dat_o_d     = '0;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        ss_tvalid_d = ss_tvalid_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        len_d       = len_q;
        x_cnt_d     = x_cnt_q;
        wait_d      = wait_q;
        y_pop       = 1'b0;
        err_clr     = 1'b0;
        do_timeout  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    wait_d  = '0;
                    addr_d  = pADDR_WIDTH'(off);
                    wdata_d = pDATA_WIDTH'(wbs_dat_i);
                    if (off < OFF_LITE_LIMIT) begin
                        if (wbs_we_i) begin
                            state_d   = ST_LWR;
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                        end else begin
                            state_d   = ST_LRD_A;
                            arvalid_d = 1'b1;
                        end
                    end else if (wbs_we_i && (off == OFF_X_IN)) begin
                        state_d     = ST_XPUSH;
                        ss_tvalid_d = 1'b1;
                    end else begin
                        // Y pop, status, or an unmapped offset: answered without any handshake
                        state_d = ST_ACK;
                        ack_d   = 1'b1;
                        if (!wbs_we_i && (off == OFF_Y_OUT)) begin
                            dat_o_d = y_full ? 32'(y_data) : 32'h0;
                            y_pop   = y_full;
                        end else if (!wbs_we_i && (off == OFF_STATUS)) begin
                            dat_o_d = status;
                            err_clr = 1'b1;
                        end
                    end
                end
            end
            ST_LWR: begin
                awvalid_d = awvalid_q && !awready;
                wvalid_d  = wvalid_q && !wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    if (addr_q == ADDR_LEN) begin
                        len_d = wdata_q;
                    end
                    if ((addr_q == ADDR_AP) && wdata_q[0]) begin
                        x_cnt_d = '0;
                    end
                end else if (timed_out) begin
                    do_timeout = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_LRD_A: begin
                if (arready) begin
                    state_d   = ST_LRD_D;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    wait_d    = '0;
                end else if (timed_out) begin
                    do_timeout = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_LRD_D: begin
                if (rvalid) begin
                    state_d  = ST_ACK;
                    rready_d = 1'b0;
                    ack_d    = 1'b1;
                    dat_o_d  = 32'(rdata);
                end else if (timed_out) begin
                    do_timeout = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_XPUSH: begin
                if (ss_tready) begin
                    state_d     = ST_ACK;
                    ss_tvalid_d = 1'b0;
                    ack_d       = 1'b1;
                    // Counter parks at zero after the frame's last sample
                    x_cnt_d     = x_last ? '0 : x_cnt_q + ONE;
                end else if (timed_out) begin
                    do_timeout = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stalled handshake is abandoned and the bus cycle completed with an error pattern
        if (do_timeout) begin
            state_d     = ST_ACK;
            ack_d       = 1'b1;
            dat_o_d     = 32'hFFFF_FFFF;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
            arvalid_d   = 1'b0;
            rready_d    = 1'b0;
            ss_tvalid_d = 1'b0;
        end

        err_d = (err_q && !err_clr) || do_timeout;
    end

    // State and registered outputs
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q     <= ST_IDLE;
            ack_q       <= 1'b0;
            dat_o_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            ss_tvalid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            len_q       <= '0;
            x_cnt_q     <= '0;
            err_q       <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            dat_o_q     <= dat_o_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            ss_tvalid_q <= ss_tvalid_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            len_q       <= len_d;
            x_cnt_q     <= x_cnt_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_o_q;
    assign awvalid   = awvalid_q;
    assign awaddr    = addr_q;
    assign wvalid    = wvalid_q;
    assign wdata     = wdata_q;
    assign arvalid   = arvalid_q;
    assign araddr    = addr_q;
    assign rready    = rready_q;
    assign ss_tvalid = ss_tvalid_q;
    assign ss_tdata  = wdata_q;
    assign ss_tlast  = x_last;

endmodule

// File: tb/tb_wb_fir_sequencer.sv
// tb/tb_wb_fir_sequencer.sv - directed self-checking bench for wb_fir_sequencer
module tb_wb_fir_sequencer;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        awvalid, wvalid, arvalid, rready, awready, wready, arready, rvalid;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic        ss_tvalid, ss_tlast, ss_tready;
    logic [31:0] ss_tdata;
    logic        sm_tready;
    logic        sm_tvalid = 1'b0, sm_tlast = 1'b0;
    logic [31:0] sm_tdata = '0;

    int n_checks = 0;
    int n_fail = 0;

    int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic ss_ready_en = 1'b1;

    logic [31:0] lite_mem [0:31];
    logic [11:0] rd_addr = '0;
    logic [11:0] aw_addr_s = '0;
    logic [31:0] w_data_s = '0;
    logic        aw_got = 1'b0, w_got = 1'b0;

    int          aw_hi = 0, w_hi = 0, ack_cnt = 0;
    int          push_cnt = 0, last_cnt = 0, last_idx = 0;
    logic [31:0] last_tdata = '0;

    wb_fir_sequencer dut (
        .axis_clk  (axis_clk),
        .axis_rst_n(axis_rst_n),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .awvalid   (awvalid),
        .awaddr    (awaddr),
        .wvalid    (wvalid),
        .wdata     (wdata),
        .awready   (awready),
        .wready    (wready),
        .arvalid   (arvalid),
        .araddr    (araddr),
        .rready    (rready),
        .arready   (arready),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .ss_tvalid (ss_tvalid),
        .ss_tdata  (ss_tdata),
        .ss_tlast  (ss_tlast),
        .ss_tready (ss_tready),
        .sm_tready (sm_tready),
        .sm_tvalid (sm_tvalid),
        .sm_tdata  (sm_tdata),
        .sm_tlast  (sm_tlast)
    );

    always #5 axis_clk = ~axis_clk;

    assign awready   = (aw_cnt >= aw_delay);
    assign wready    = (w_cnt >= w_delay);
    assign arready   = (ar_cnt >= ar_delay);
    assign rvalid    = rready && (r_cnt >= r_delay);
    assign rdata     = lite_mem[rd_addr[6:2]];
    assign ss_tready = ss_ready_en;

    always @(posedge axis_clk) begin
        aw_cnt <= awvalid ? aw_cnt + 1 : 0;
        w_cnt  <= wvalid ? w_cnt + 1 : 0;
        ar_cnt <= arvalid ? ar_cnt + 1 : 0;
        r_cnt  <= rready ? r_cnt + 1 : 0;
    end

    always @(negedge axis_clk) begin
        if (awvalid) aw_hi = aw_hi + 1;
        if (wvalid) w_hi = w_hi + 1;
        if (wbs_ack_o) ack_cnt = ack_cnt + 1;
        if (awvalid && awready) begin aw_addr_s = awaddr; aw_got = 1'b1; end
        if (wvalid && wready) begin w_data_s = wdata; w_got = 1'b1; end
        if (aw_got && w_got) begin
            lite_mem[aw_addr_s[6:2]] = w_data_s;
            aw_got = 1'b0;
            w_got  = 1'b0;
        end
        if (arvalid && arready) rd_addr = araddr;
        if (ss_tvalid && ss_tready) begin
            push_cnt   = push_cnt + 1;
            last_tdata = ss_tdata;
            if (ss_tlast) begin
                last_cnt = last_cnt + 1;
                last_idx = push_cnt;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                           input int max_cyc, output logic [31:0] rd, output logic acked,
                           output int lat);
        @(posedge axis_clk); #1;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = wd;
        acked = 1'b0;
        lat   = 0;
        rd    = '0;
        for (int i = 1; i <= max_cyc && !acked; i++) begin
            @(posedge axis_clk); #1;
            if (wbs_ack_o) begin
                acked = 1'b1;
                lat   = i;
                rd    = wbs_dat_o;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wb_acc(input string tag, input logic we, input logic [31:0] adr,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat);
        logic acked;
        wb_xfer(we, adr, wd, 400, rd, acked, lat);
        check_eq({tag, " ack"}, 32'(acked), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        acked;
        int          lat;
        int          acks_before;

        for (int i = 0; i < 32; i++) lite_mem[i] = '0;

        #23;
        check_eq("rst ack", 32'(wbs_ack_o), 32'd0);
        check_eq("rst dat_o", wbs_dat_o, 32'd0);
        check_eq("rst awvalid", 32'(awvalid), 32'd0);
        check_eq("rst ss_tlast", 32'(ss_tlast), 32'd0);
        check_eq("rst sm_tready", 32'(sm_tready), 32'd1);
        @(negedge axis_clk);
        axis_rst_n = 1'b1;

        // Lite write with ready already high: ack two cycles after strobe
        wb_acc("lite wr fast", 1'b1, 32'h3000_0020, 32'h0000_00AA, rd, lat);
        check_eq("lite wr fast latency", 32'(lat), 32'd2);
        check_eq("lite wr fast mem", lite_mem[8], 32'h0000_00AA);

        // LEN write with awready two cycles after wready
        aw_delay = 3; w_delay = 1;
        aw_hi = 0; w_hi = 0; acks_before = ack_cnt;
        wb_acc("len wr", 1'b1, 32'h3000_0010, 32'd64, rd, lat);
        check_eq("len wr dat", rd, 32'd0);
        check_eq("len wr aw cycles", 32'(aw_hi), 32'd4);
        check_eq("len wr w cycles", 32'(w_hi), 32'd2);
        check_eq("len wr mem", lite_mem[4], 32'd64);
        @(negedge axis_clk);
        check_eq("len wr single ack", 32'(ack_cnt - acks_before), 32'd1);
        aw_delay = 0; w_delay = 0;

        r_delay = 1; ar_delay = 1;
        wb_acc("len rd", 1'b0, 32'h3000_0010, 32'd0, rd, lat);
        check_eq("len rd data", rd, 32'd64);
        r_delay = 0; ar_delay = 0;

        // ap_start then a 64-sample frame
        wb_acc("ap_start", 1'b1, 32'h3000_0000, 32'd1, rd, lat);
        push_cnt = 0; last_cnt = 0; last_idx = 0;
        for (int i = 0; i < 63; i++) wb_acc("x push", 1'b1, 32'h3000_0080, 32'h100 + 32'(i), rd, lat);
        wb_acc("status 63", 1'b0, 32'h3000_0088, 32'd0, rd, lat);
        check_eq("status x_cnt 63", rd, 32'h003F_0002);
        check_eq("tlast armed", 32'(ss_tlast), 32'd1);
        check_eq("tlast not early", 32'(last_cnt), 32'd0);
        wb_acc("x push 64", 1'b1, 32'h3000_0080, 32'h13F, rd, lat);
        wb_acc("status 0", 1'b0, 32'h3000_0088, 32'd0, rd, lat);
        check_eq("status x_cnt 0", rd, 32'h0000_0002);
        check_eq("push count", 32'(push_cnt), 32'd64);
        check_eq("tlast count", 32'(last_cnt), 32'd1);
        check_eq("tlast index", 32'(last_idx), 32'd64);
        check_eq("last tdata", last_tdata, 32'h0000_013F);
        check_eq("tlast idle", 32'(ss_tlast), 32'd0);

        // Y capture and pop
        @(posedge axis_clk); #1;
        sm_tvalid = 1'b1; sm_tdata = 32'h0000_1234; sm_tlast = 1'b1;
        @(posedge axis_clk); #1;
        sm_tvalid = 1'b0; sm_tdata = '0; sm_tlast = 1'b0;
        check_eq("y full tready", 32'(sm_tready), 32'd0);
        wb_acc("status y", 1'b0, 32'h3000_0088, 32'd0, rd, lat);
        check_eq("status y full", rd, 32'h0000_000B);
        wb_acc("y pop", 1'b0, 32'h3000_0084, 32'd0, rd, lat);
        check_eq("y pop data", rd, 32'h0000_1234);
        check_eq("y pop tready", 32'(sm_tready), 32'd1);
        wb_acc("status y2", 1'b0, 32'h3000_0088, 32'd0, rd, lat);
        check_eq("status y empty", rd & 32'h1, 32'd0);
        wb_acc("y pop empty", 1'b0, 32'h3000_0084, 32'd0, rd, lat);
        check_eq("y pop empty data", rd, 32'd0);
        check_eq("y pop empty latency", 32'(lat), 32'd1);

        // X push timeout
        ss_ready_en = 1'b0;
        push_cnt = 0;
        wb_acc("x timeout", 1'b1, 32'h3000_0080, 32'h5555_AAAA, rd, lat);
        check_eq("x timeout data", rd, 32'hFFFF_FFFF);
        check_eq("x timeout tvalid", 32'(ss_tvalid), 32'd0);
        wb_acc("status err", 1'b0, 32'h3000_0088, 32'd0, rd, lat);
        check_eq("status err set", rd & 32'hFFFF_0007, 32'h0000_0004);
        ss_ready_en = 1'b1;
        wb_acc("status err2", 1'b0, 32'h3000_0088, 32'd0, rd, lat);
        check_eq("status err cleared", rd & 32'hFFFF_0007, 32'h0000_0002);
        check_eq("x timeout no push", 32'(push_cnt), 32'd0);

        // Unmapped offset and foreign base address
        wb_acc("unmapped", 1'b0, 32'h3000_0100, 32'd0, rd, lat);
        check_eq("unmapped data", rd, 32'd0);
        check_eq("unmapped latency", 32'(lat), 32'd1);
        wb_xfer(1'b0, 32'h3800_0000, 32'd0, 20, rd, acked, lat);
        check_eq("foreign base no ack", 32'(acked), 32'd0);

        // Reset in the middle of a Lite write
        aw_delay = 1000; w_delay = 1000;
        @(posedge axis_clk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h3000_0004; wbs_dat_i = 32'h0000_0077;
        repeat (3) begin @(posedge axis_clk); #1; end
        check_eq("mid lwr awvalid", 32'(awvalid), 32'd1);
        acks_before = ack_cnt;
        #2;
        axis_rst_n = 1'b0;
        #1;
        check_eq("rst awvalid drop", 32'(awvalid), 32'd0);
        check_eq("rst wvalid drop", 32'(wvalid), 32'd0);
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        repeat (2) @(negedge axis_clk);
        axis_rst_n = 1'b1;
        aw_delay = 0; w_delay = 0;
        repeat (3) @(negedge axis_clk);
        check_eq("rst no ack", 32'(ack_cnt - acks_before), 32'd0);
        wb_acc("post rst status", 1'b0, 32'h3000_0088, 32'd0, rd, lat);
        check_eq("post rst status data", rd, 32'h0000_0002);
        check_eq("post rst status latency", 32'(lat), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
